// File: rtl/stage_d_writeback_queue_pkg.sv
// Shared definitions for the data write-back queue stage.
// Opcode bit positions mirror the shared bfcpu2 Constants.v. They are one-hot
// bit indices into the operation vector. The write-op decode is local here.
package stage_d_writeback_queue_pkg;
  localparam int OPCODE_MSB = 7;
  localparam int OP_INC     = 0;
  localparam int OP_DEC     = 1;
  localparam int OP_LEFT    = 2;
  localparam int OP_RIGHT   = 3;
  localparam int OP_OUT     = 4;
  localparam int OP_IN      = 5;
  localparam int OP_JZ      = 6;
  localparam int OP_JNZ     = 7;

  // Operations that store to data memory.
  function automatic logic is_write_op(input logic [OPCODE_MSB:0] op);
    return op[OP_INC] | op[OP_DEC] | op[OP_IN];
  endfunction
endpackage

// File: rtl/stage_d_writeback_queue_fifo.sv
// wb_fifo: circular write queue with the following features:
//   - push at the tail
//   - overwrite of the newest (tail) entry, used for coalescing
//   - pop at the head
//   - newest-first store-to-load forwarding search
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   push_i, ovw_i, pop_i    enqueue / overwrite newest entry data / retire head
//   addr_i, data_i          entry written by push (ovw uses data_i only)
//   count_o                 number of valid entries, 0..DEPTH
//   head_addr_o/_data_o     oldest entry
//   tail_addr_o             address of the newest entry
//   rd_a_i, fwd_hit_o, fwd_q_o  forwarding lookup
module wb_fifo #(
  parameter int A_WIDTH = 12,
  parameter int D_WIDTH = 8,
  parameter int DEPTH   = 4,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = PW + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push_i,
  input  logic               ovw_i,
  input  logic               pop_i,
  input  logic [A_WIDTH-1:0] addr_i,
  input  logic [D_WIDTH-1:0] data_i,
  output logic [CW-1:0]      count_o,
  output logic [A_WIDTH-1:0] head_addr_o,
  output logic [D_WIDTH-1:0] head_data_o,
  output logic [A_WIDTH-1:0] tail_addr_o,
  input  logic [A_WIDTH-1:0] rd_a_i,
  output logic               fwd_hit_o,
  output logic [D_WIDTH-1:0] fwd_q_o
);
  logic [A_WIDTH-1:0] addr_q [DEPTH];
  logic [D_WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d, tail_m1;
  logic [CW-1:0]      count_q, count_d;

  // tail_q points at the next free slot; the newest entry sits one behind.
  assign tail_m1 = tail_q - PW'(1);

  always_comb begin
    head_d  = head_q + PW'(pop_i);
    tail_d  = tail_q + PW'(push_i);
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[tail_q] <= addr_i;
      data_q[tail_q] <= data_i;
    end else if (ovw_i) begin
      data_q[tail_m1] <= data_i;
    end
  end

  assign count_o     = count_q;
  assign head_addr_o = addr_q[head_q];
  assign head_data_o = data_q[head_q];
  assign tail_addr_o = addr_q[tail_m1];

  // Scan oldest to newest. A later match overrides an earlier one, so the
  // newest matching entry wins.
  always_comb begin
    fwd_hit_o = 1'b0;
    fwd_q_o   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q && addr_q[head_q + PW'(i)] == rd_a_i) begin
        fwd_hit_o = 1'b1;
        fwd_q_o   = data_q[head_q + PW'(i)];
      end
    end
  end
endmodule

// File: rtl/stage_d_writeback_queue.sv
// Data write-back stage with a buffered, coalescing write queue.
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   dp, a_in, operation_in        incoming op, its data address and value
//   drdy_in, ack_in               sideband, registered to drdy / ack
//   stall                         upstream must hold its inputs this cycle
//   dce, da, dq, dbusy            data-memory write port (head of queue)
//   rd_a, fwd_hit, fwd_q          store-to-load forwarding lookup
//   operation, drdy, ack          registered sideband (bubble on stall)
module stage_d_writeback_queue
  import stage_d_writeback_queue_pkg::*;
#(
  parameter int A_WIDTH = 12,
  parameter int D_WIDTH = 8,
  parameter int DEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [A_WIDTH-1:0]  dp,
  input  logic [D_WIDTH-1:0]  a_in,
  input  logic [OPCODE_MSB:0] operation_in,
  input  logic                drdy_in,
  input  logic                ack_in,
  output logic                stall,
  output logic                dce,
  output logic [A_WIDTH-1:0]  da,
  output logic [D_WIDTH-1:0]  dq,
  input  logic                dbusy,
  input  logic [A_WIDTH-1:0]  rd_a,
  output logic                fwd_hit,
  output logic [D_WIDTH-1:0]  fwd_q,
  output logic [OPCODE_MSB:0] operation,
  output logic                drdy,
  output logic                ack
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                wr_op, pop, coalesce, push, ovw;
  logic [CW-1:0]       count;
  logic [A_WIDTH-1:0]  tail_addr;
  logic [OPCODE_MSB:0] operation_q, operation_d;
  logic                drdy_q, drdy_d, ack_q;

  assign wr_op = is_write_op(operation_in);
  // dce is driven from registered count only; reset masks it immediately.
  assign dce   = reset_n && (count != '0);
  assign pop   = dce && !dbusy;

  // With a single entry being popped, the tail is leaving, so it cannot
  // absorb the new write; it must be pushed behind it instead.
  assign coalesce = wr_op && (count != '0) && (dp == tail_addr) &&
                    !(pop && count == CW'(1));
  // Full-queue stall ignores a same-edge pop to keep it off the dbusy path.
  assign stall    = (count == CW'(DEPTH)) && !coalesce;
  assign ovw      = coalesce && !stall;
  assign push     = wr_op && !coalesce && !stall;

  wb_fifo #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .ovw_i       (ovw),
    .pop_i       (pop),
    .addr_i      (dp),
    .data_i      (a_in),
    .count_o     (count),
    .head_addr_o (da),
    .head_data_o (dq),
    .tail_addr_o (tail_addr),
    .rd_a_i      (rd_a),
    .fwd_hit_o   (fwd_hit),
    .fwd_q_o     (fwd_q)
  );

  // A stalled op is replaced by a bubble downstream; ack always follows.
  always_comb begin
    operation_d = stall ? '0 : operation_in;
    drdy_d      = stall ? 1'b0 : drdy_in;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      operation_q <= '0;
      drdy_q      <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      operation_q <= operation_d;
      drdy_q      <= drdy_d;
      ack_q       <= ack_in;
    end
  end

  assign operation = operation_q;
  assign drdy      = drdy_q;
  assign ack       = ack_q;
endmodule

// File: doc/stage_d_writeback_queue.md
# stage_d_writeback_queue

Parametrised successor of the data write-back stage of the bfcpu2 pipeline. Registers the operation, `drdy` and `ack` sideband exactly like a plain write-back stage. Buffers data-memory writes from INC/DEC/IN in a DEPTH-entry FIFO so a slow data memory (`dbusy`) no longer loses writes. Adds same-address write coalescing and combinational store-to-load forwarding for the read stage.

## Interface
- `A_WIDTH`, 12, data address width
- `D_WIDTH`, 8, data word width
- `DEPTH`, 4, write-queue entries; power of two, ≥ 2

- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `dp`  in  A_WIDTH  data pointer for the incoming operation
- `a_in`  in  D_WIDTH  value to write for the incoming operation
- `operation_in`  in  `OPCODE_MSB`+1  one-hot operation from the previous stage
- `drdy_in`  in  1  data-ready from the previous stage
- `ack_in`  in  1  ack from the next stage
- `stall`  out  1  combinational; upstream must hold its inputs this cycle
- `dce`  out  1  data-memory write strobe; head entry valid
- `da`  out  A_WIDTH  head entry address
- `dq`  out  D_WIDTH  head entry data
- `dbusy`  in  1  memory refuses the write this cycle
- `rd_a`  in  A_WIDTH  forwarding lookup address
- `fwd_hit`  out  1  combinational; some queued entry matches `rd_a`
- `fwd_q`  out  D_WIDTH  data of the newest matching entry; 0 when no hit
- `operation`  out  `OPCODE_MSB`+1  registered operation
- `drdy`  out  1  registered `drdy_in`
- `ack`  out  1  registered `ack_in`

## Operation
- A write op has `OP_INC`, `OP_DEC` or `OP_IN` set in `operation_in`.
- Pop: `dce && !dbusy` at a clock edge retires the head entry.
- Coalesce condition: write op, `count ≥ 1`, `dp` equals the tail address, and the tail is not being popped this edge.
  - When it holds, the tail data is overwritten with `a_in` and `count` is unchanged.
  - With `count == 1` and a pop in the same edge, the condition is false, so the write becomes a normal push.
- Otherwise a write op pushes `{dp, a_in}` at the tail.
- `stall = (count == DEPTH) && !(write op && coalesce condition)`.
  - Stall depends only on registered `count`, never on the same-cycle pop. A full queue stalls for one cycle even if it frees an entry at that edge.
- While `stall`: no push and no coalesce. `operation <= 0` and `drdy <= 0` (a bubble is inserted). `ack <= ack_in` still updates.
- While not stalled: `operation <= operation_in`, `drdy <= drdy_in`, `ack <= ack_in`.
- Simultaneous push and pop: the head advances, the tail advances, and `count` is unchanged.
- Forwarding: search from newest to oldest over valid entries. Entries written at the current edge are not visible until the next cycle.
- Pointers are `log2(DEPTH)` bits and wrap naturally. `count` is `log2(DEPTH)+1` bits, range 0..DEPTH.

## Timing
- Reset (`reset_n == 0` at an edge):
  - `count`, the head/tail pointers, `operation`, `drdy` and `ack` are cleared to 0.
  - Pending writes are discarded.
  - `dce` is forced to 0 combinationally while `reset_n` is low.
  - `da`/`dq` are don't-care while `dce` is 0. `fwd_hit` is 0 and `fwd_q` is 0 after reset.
- Latency:
  - A write op accepted at edge N is presented on `dce`/`da`/`dq` in cycle N+1 at the earliest, when the queue was empty.
  - Queue throughput is 1 write/cycle when `dbusy` stays 0.
- `operation`/`drdy`/`ack` have 1 cycle of latency, matching the previous generation.
- `dce`, `da` and `dq` are functions of registered state only. The memory may sample them at any edge.
- A reset mid-drain drops the head even if `dbusy` was low in that cycle.

## Structure
- `OPCODE_MSB`, `OP_INC`, `OP_DEC` and `OP_IN` come from the shared `Constants.v`; this block adds no new constants.
- The write-op decode function is local to this block.
- Sub-module `wb_fifo`: storage arrays, head/tail/count, push/pop/overwrite-tail ports, and the forwarding search. The top level holds the decode, coalesce/stall logic and sideband registers.

## Test plan
- Empty queue, `dbusy = 0`, INC at dp 0x010 with a_in 0x05 → next cycle `dce = 1`, `da = 0x010`, `dq = 0x05`; following cycle `dce = 0`.
- `dbusy = 1`, four writes to 0x001..0x004, then a fifth to 0x005 → `stall = 1` and `operation = 0` in the next cycle. Release `dbusy` → drain order 0x001..0x005 with no loss.
- `dbusy = 1`, writes 0x020 := 1 then 0x020 := 2 → `count` stays 1. Release → a single memory write of 0x020 := 2.
- Queue holds 0x030 := 7 then 0x031 := 8, `rd_a = 0x030` → `fwd_hit = 1`, `fwd_q = 7`. With `rd_a = 0x032` → `fwd_hit = 0`, `fwd_q = 0`.
- Full queue with `dbusy = 1`, assert `reset_n = 0` for one edge → `dce = 0` and `count = 0`. After release, no stale write appears.
- `count = 1`, head popping at the same edge as a write to the head address → push (not coalesce). Both writes reach memory in order.
